sdram_init_fsm: RTL and testbench

SDRAM_INIT_FSM -- requirements
Module: sdram_init_fsm

---
 rtl/sdram_pkg.sv | 58 +++++
 rtl/sdram_init_timer.sv | 34 +++
 rtl/sdram_init_fsm.sv | 185 ++++++++++++++++++
 tb/tb_sdram_init_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM init definitions: command encodings, FSM state enum, mode-word helpers.
// The EMRS states exist only when SDRAM_INIT_EMRS_EN is defined.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_PRE,
    ST_WAIT_RP,
    ST_AREF,
    ST_WAIT_RFC,
    ST_LMR,
    ST_WAIT_MRD,
`ifdef SDRAM_INIT_EMRS_EN
    ST_EMRS,
    ST_WAIT_EMRD,
`endif
    ST_DONE
  } state_t;

  function automatic logic [2:0] bl_code(input int burst_len);
    logic [2:0] code_s;
    case (burst_len)
      1:       code_s = 3'b000;
      2:       code_s = 3'b001;
      4:       code_s = 3'b010;
      8:       code_s = 3'b011;
      default: code_s = 3'b010;
    endcase
    return code_s;
  endfunction

  // Mode register bits A9..A0: {WR_BURST, 2'b00, CAS, BT, BL}.
  function automatic logic [9:0] mode_word(input int burst_len, input int burst_type,
                                           input int cas_lat, input int wr_burst);
    logic [31:0] bt_s;
    logic [31:0] cl_s;
    logic [31:0] wb_s;
    bt_s = burst_type;
    cl_s = cas_lat;
    wb_s = wr_burst;
    return {wb_s[0], 2'b00, cl_s[2:0], bt_s[0], bl_code(burst_len)};
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Down-counting wait timer: start loads the count, done pulses for one cycle when it hits zero.
module sdram_init_timer #(
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CNT_W-1:0] load,
  input  logic             start,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;
  logic             run_r;

  // Load on start, then count down to zero and stop without wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      run_r <= 1'b0;
    end else if (start) begin
      cnt_r <= load;
      run_r <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign done = run_r & (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sdram_init_fsm.sv
// SDRAM power-up initialisation sequencer: PWRUP, PRE, AREF x AREF_NUM, LMR, then DONE.
// Define SDRAM_INIT_EMRS_EN to add an extended mode register load (EMRS) before DONE.
module sdram_init_fsm
  import sdram_pkg::*;
#(
  parameter int T_PWRUP_CYC = 13333,
  parameter int T_RP_CYC    = 3,
  parameter int T_RFC_CYC   = 9,
  parameter int T_MRD_CYC   = 2,
  parameter int AREF_NUM    = 2,
  parameter int ADDR_BITS   = 12,
  parameter int BA_BITS     = 2,
  parameter int BURST_LEN   = 4,
  parameter int BURST_TYPE  = 0,
  parameter int CAS_LAT     = 3,
  parameter int WR_BURST    = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 init_req,
  output logic [3:0]           cmd,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic                 sdram_cke,
  output logic                 init_busy,
  output logic                 init_done
);

  localparam int T_MAX = max4(T_PWRUP_CYC, T_RP_CYC, T_RFC_CYC, T_MRD_CYC);
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // The timer starts one edge after a command is issued, hence the -2 on command waits.
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(T_RP_CYC - 2);
  localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(T_RFC_CYC - 2);
  localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD_CYC - 2);

  localparam logic [ADDR_BITS-1:0] ADDR_A10  = ADDR_BITS'(11'h400);
  localparam logic [ADDR_BITS-1:0] ADDR_MODE =
    {{(ADDR_BITS-10){1'b0}}, mode_word(BURST_LEN, BURST_TYPE, CAS_LAT, WR_BURST)};
  localparam logic [3:0] AREF_NUM_C = 4'(AREF_NUM);

  state_t           state_r;
  logic [3:0]       aref_cnt_r;
  logic             pwrup_arm_r;
  logic             tmr_start_s;
  logic [CNT_W-1:0] tmr_load_s;
  logic             tmr_done_s;

  sdram_init_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .load     (tmr_load_s),
    .start    (tmr_start_s),
    .done     (tmr_done_s)
  );

  // Timer start/load decode: each command state arms the wait that follows it.
  always_comb begin
    tmr_start_s = 1'b0;
    tmr_load_s  = LD_PWRUP;
    case (state_r)
      ST_PWRUP: begin
        tmr_start_s = pwrup_arm_r;
        tmr_load_s  = LD_PWRUP;
      end
      ST_PRE: begin
        tmr_start_s = 1'b1;
        tmr_load_s  = LD_RP;
      end
      ST_AREF: begin
        tmr_start_s = 1'b1;
        tmr_load_s  = LD_RFC;
      end
      ST_LMR: begin
        tmr_start_s = 1'b1;
        tmr_load_s  = LD_MRD;
      end
`ifdef SDRAM_INIT_EMRS_EN
      ST_EMRS: begin
        tmr_start_s = 1'b1;
        tmr_load_s  = LD_MRD;
      end
`endif
      default: begin
        tmr_start_s = 1'b0;
        tmr_load_s  = LD_PWRUP;
      end
    endcase
  end

  // Sequencer state and registered SDRAM outputs; commands last one cycle, NOP otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_PWRUP;
      aref_cnt_r  <= 4'd0;
      pwrup_arm_r <= 1'b1;
      cmd         <= CMD_NOP;
      sdram_addr  <= ADDR_A10;
      sdram_ba    <= {BA_BITS{1'b0}};
      sdram_cke   <= 1'b0;
      init_done   <= 1'b0;
      init_busy   <= 1'b1;
    end else begin
      sdram_cke  <= 1'b1;
      cmd        <= CMD_NOP;
      sdram_addr <= ADDR_A10;
      sdram_ba   <= {BA_BITS{1'b0}};
      case (state_r)
        ST_PWRUP: begin
          pwrup_arm_r <= 1'b0;
          if (tmr_done_s) begin
            state_r    <= ST_PRE;
            cmd        <= CMD_PRE;
            aref_cnt_r <= 4'd0;
          end
        end
        ST_PRE: state_r <= ST_WAIT_RP;
        ST_WAIT_RP: begin
          if (tmr_done_s) begin
            state_r    <= ST_AREF;
            cmd        <= CMD_AREF;
            aref_cnt_r <= aref_cnt_r + 4'd1;
          end
        end
        ST_AREF: state_r <= ST_WAIT_RFC;
        ST_WAIT_RFC: begin
          if (tmr_done_s) begin
            if (aref_cnt_r == AREF_NUM_C) begin
              state_r    <= ST_LMR;
              cmd        <= CMD_LMR;
              sdram_addr <= ADDR_MODE;
            end else begin
              state_r    <= ST_AREF;
              cmd        <= CMD_AREF;
              aref_cnt_r <= aref_cnt_r + 4'd1;
            end
          end
        end
        ST_LMR: state_r <= ST_WAIT_MRD;
        ST_WAIT_MRD: begin
          if (tmr_done_s) begin
`ifdef SDRAM_INIT_EMRS_EN
            state_r    <= ST_EMRS;
            cmd        <= CMD_LMR;
            sdram_addr <= {ADDR_BITS{1'b0}};
            sdram_ba   <= BA_BITS'(2'b01);
`else
            state_r   <= ST_DONE;
            init_done <= 1'b1;
            init_busy <= 1'b0;
`endif
          end
        end
`ifdef SDRAM_INIT_EMRS_EN
        ST_EMRS: state_r <= ST_WAIT_EMRD;
        ST_WAIT_EMRD: begin
          if (tmr_done_s) begin
            state_r   <= ST_DONE;
            init_done <= 1'b1;
            init_busy <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (init_req) begin
            state_r    <= ST_PRE;
            cmd        <= CMD_PRE;
            aref_cnt_r <= 4'd0;
            init_done  <= 1'b0;
            init_busy  <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_PWRUP;
          init_done <= 1'b0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_init_fsm.sv
// Directed bench for sdram_init_fsm: default build plus a long-refresh / BL8 instance.
module tb_sdram_init_fsm;

`ifdef SDRAM_INIT_EMRS_EN
  localparam int EMRS_EN = 1;
`else
  localparam int EMRS_EN = 0;
`endif

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_req_a, init_req_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [11:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic        cke_a, cke_b, busy_a, busy_b, done_a, done_b;

  always #5 sys_clk = ~sys_clk;

  sdram_init_fsm #(.T_PWRUP_CYC(10)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_req(init_req_a),
    .cmd(cmd_a), .sdram_addr(addr_a), .sdram_ba(ba_a), .sdram_cke(cke_a),
    .init_busy(busy_a), .init_done(done_a));

  sdram_init_fsm #(.T_PWRUP_CYC(10), .AREF_NUM(4), .T_RFC_CYC(7),
                   .BURST_LEN(8), .CAS_LAT(2), .BURST_TYPE(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_req(init_req_b),
    .cmd(cmd_b), .sdram_addr(addr_b), .sdram_ba(ba_b), .sdram_cke(cke_b),
    .init_busy(busy_b), .init_done(done_b));

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  ba;
    logic        done;
  } vec_t;

  vec_t vec_a[$];
  vec_t vec_b[$];

  logic [3:0]  cmd_la [64], cmd_lb [64];
  logic [11:0] addr_la[64], addr_lb[64];
  logic [1:0]  ba_la  [64], ba_lb  [64];
  logic        done_la[64], done_lb[64], busy_la[64], busy_lb[64], cke_la[64];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic capture(input int c);
    cmd_la[c] = cmd_a;  addr_la[c] = addr_a; ba_la[c] = ba_a;
    done_la[c] = done_a; busy_la[c] = busy_a; cke_la[c] = cke_a;
    cmd_lb[c] = cmd_b;  addr_lb[c] = addr_b; ba_lb[c] = ba_b;
    done_lb[c] = done_b; busy_lb[c] = busy_b;
  endtask

  // Log n cycles; cycle c is sampled 1 time unit after the c-th edge since release.
  task automatic run_log(input int n, input int req_cyc);
    for (int c = 0; c < n; c++) begin
      @(posedge sys_clk); #1;
      capture(c);
      init_req_a = (c == req_cyc);
    end
    init_req_a = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " cmd_a"},  32'(cmd_a),  32'(NOP));
    check({tag, " addr_a"}, 32'(addr_a), 32'h400);
    check({tag, " ba_a"},   32'(ba_a),   32'h0);
    check({tag, " cke_a"},  32'(cke_a),  32'h0);
    check({tag, " done_a"}, 32'(done_a), 32'h0);
    check({tag, " busy_a"}, 32'(busy_a), 32'h1);
    check({tag, " cke_b"},  32'(cke_b),  32'h0);
    check({tag, " done_b"}, 32'(done_b), 32'h0);
  endtask

  task automatic check_table_a(input string tag);
    foreach (vec_a[i]) begin
      check($sformatf("%s a cmd@%0d", tag, vec_a[i].cyc), 32'(cmd_la[vec_a[i].cyc]), 32'(vec_a[i].cmd));
      check($sformatf("%s a addr@%0d", tag, vec_a[i].cyc), 32'(addr_la[vec_a[i].cyc]), 32'(vec_a[i].addr));
      check($sformatf("%s a ba@%0d", tag, vec_a[i].cyc), 32'(ba_la[vec_a[i].cyc]), 32'(vec_a[i].ba));
      check($sformatf("%s a done@%0d", tag, vec_a[i].cyc), 32'(done_la[vec_a[i].cyc]), 32'(vec_a[i].done));
    end
  endtask

  initial begin
    int n_cmd;
    int n_bad;
    sys_rst_n  = 1'b0;
    init_req_a = 1'b0;
    init_req_b = 1'b0;

    vec_a.push_back('{0,  NOP,  12'h400, 2'b00, 1'b0});
    vec_a.push_back('{9,  NOP,  12'h400, 2'b00, 1'b0});
    vec_a.push_back('{10, PRE,  12'h400, 2'b00, 1'b0});
    vec_a.push_back('{11, NOP,  12'h400, 2'b00, 1'b0});
    vec_a.push_back('{12, NOP,  12'h400, 2'b00, 1'b0});
    vec_a.push_back('{13, AREF, 12'h400, 2'b00, 1'b0});
    vec_a.push_back('{21, NOP,  12'h400, 2'b00, 1'b0});
    vec_a.push_back('{22, AREF, 12'h400, 2'b00, 1'b0});
    vec_a.push_back('{30, NOP,  12'h400, 2'b00, 1'b0});
    vec_a.push_back('{31, LMR,  12'h032, 2'b00, 1'b0});
    vec_a.push_back('{32, NOP,  12'h400, 2'b00, 1'b0});
`ifdef SDRAM_INIT_EMRS_EN
    vec_a.push_back('{33, LMR,  12'h000, 2'b01, 1'b0});
    vec_a.push_back('{34, NOP,  12'h400, 2'b00, 1'b0});
`endif
    vec_a.push_back('{33 + 2*EMRS_EN, NOP, 12'h400, 2'b00, 1'b1});

    vec_b.push_back('{10, PRE,  12'h400, 2'b00, 1'b0});
    vec_b.push_back('{13, AREF, 12'h400, 2'b00, 1'b0});
    vec_b.push_back('{20, AREF, 12'h400, 2'b00, 1'b0});
    vec_b.push_back('{27, AREF, 12'h400, 2'b00, 1'b0});
    vec_b.push_back('{34, AREF, 12'h400, 2'b00, 1'b0});
    vec_b.push_back('{40, NOP,  12'h400, 2'b00, 1'b0});
    vec_b.push_back('{41, LMR,  12'h02B, 2'b00, 1'b0});
    vec_b.push_back('{42 + 2*EMRS_EN, NOP, 12'h400, 2'b00, 1'b0});
    vec_b.push_back('{43 + 2*EMRS_EN, NOP, 12'h400, 2'b00, 1'b1});

    // Power-on reset, then full sequence with an init_req pulse at cycle 20 that must be ignored.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_vals("por");
    sys_rst_n = 1'b1;
    run_log(64, 20);
    check("cke_a after release", 32'(cke_la[0]), 32'h1);
    check_table_a("init");
    foreach (vec_b[i]) begin
      check($sformatf("b cmd@%0d", vec_b[i].cyc), 32'(cmd_lb[vec_b[i].cyc]), 32'(vec_b[i].cmd));
      check($sformatf("b addr@%0d", vec_b[i].cyc), 32'(addr_lb[vec_b[i].cyc]), 32'(vec_b[i].addr));
      check($sformatf("b done@%0d", vec_b[i].cyc), 32'(done_lb[vec_b[i].cyc]), 32'(vec_b[i].done));
    end
    n_cmd = 0;
    n_bad = 0;
    for (int c = 0; c < 64; c++) begin
      if (cmd_la[c] != NOP) n_cmd++;
      if (busy_la[c] !== ~done_la[c]) n_bad++;
      if (busy_lb[c] !== ~done_lb[c]) n_bad++;
    end
    check("a command count", 32'(n_cmd), 32'(4 + EMRS_EN));
    check("busy == ~done", 32'(n_bad), 32'h0);
    n_cmd = 0;
    for (int c = 0; c < 64; c++) if (cmd_lb[c] != NOP) n_cmd++;
    check("b command count", 32'(n_cmd), 32'(6 + EMRS_EN));

    // Re-initialisation from DONE: PRE on the very next cycle, no power-up wait.
    init_req_a = 1'b1;
    @(posedge sys_clk); #1;
    init_req_a = 1'b0;
    check("reinit cmd", 32'(cmd_a), 32'(PRE));
    check("reinit done", 32'(done_a), 32'h0);
    check("reinit busy", 32'(busy_a), 32'h1);
    for (int k = 1; k < 32; k++) begin
      @(posedge sys_clk); #1;
      capture(k);
    end
    check("reinit nop@2", 32'(cmd_la[2]), 32'(NOP));
    check("reinit aref@3", 32'(cmd_la[3]), 32'(AREF));
    check("reinit aref@12", 32'(cmd_la[12]), 32'(AREF));
    check("reinit lmr@21", 32'(cmd_la[21]), 32'(LMR));
    check("reinit lmr addr", 32'(addr_la[21]), 32'h032);
    check("reinit done low", 32'(done_la[22 + 2*EMRS_EN]), 32'h0);
    check("reinit done high", 32'(done_la[23 + 2*EMRS_EN]), 32'h1);
    check("b unaffected", 32'(done_b), 32'h1);

    // Fresh start, then asynchronous reset mid-sequence at cycle 15.
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      @(posedge sys_clk); #1;
      capture(c);
    end
    check("pre-reset aref@13", 32'(cmd_la[13]), 32'(AREF));
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_vals("held");
    sys_rst_n = 1'b1;
    run_log(40, -1);
    check("restart cke@0", 32'(cke_la[0]), 32'h1);
    check_table_a("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
